// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and IT sequencer states for the conditional-execution unit.
package cond_pkg;
  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition check of a cond_t against {N,Z,C,V}.
module cond_eval
  import cond_pkg::*;
(
  input  cond_t      cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];
  always_comb begin
    pass = 1'b1;
    case (cond)
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = n == v;
      LT: pass = n != v;
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe: Execute-stage condition unit with grouped NZCV register and gated E->M write controls.
// Define COND_IT_BLOCK_EN to add the Thumb-style IT sequencer.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int NGROUPS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_e,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic [3:0]         cond_e,
  input  logic [3:0]         alu_flags_e,
  input  logic [NGROUPS-1:0] flag_w_e,
  input  logic               pcs_e,
  input  logic               reg_w_e,
  input  logic               mem_w_e,
  input  logic               no_write_e,
  input  logic               it_start_e,
  input  logic [3:0]         it_cond_e,
  input  logic [3:0]         it_mask_e,
  output logic               cond_ex_e,
  output logic               pc_src_e,
  output logic               reg_write_m,
  output logic               mem_write_m,
  output logic [3:0]         flags,
  output logic               it_active
);
  localparam int GW = 4 / NGROUPS;
  logic       go;
  logic [3:0] eff_cond;
  assign go = valid_e & ~stall_e & ~flush_e;
  cond_eval u_eval (.cond(cond_t'(eff_cond)), .flags(flags), .pass(cond_ex_e));
  assign pc_src_e = pcs_e & cond_ex_e & go;
  for (genvar g = 0; g < NGROUPS; g++) begin : g_flag
    logic [GW-1:0] q;
    always_ff @(posedge clk or negedge reset)
      if (!reset) q <= '0;
      else if (flag_w_e[g] & cond_ex_e & go) q <= alu_flags_e[g*GW +: GW];
    assign flags[g*GW +: GW] = q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
    end else if (flush_e) begin
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
    end else if (!stall_e) begin
      reg_write_m <= reg_w_e & ~no_write_e & cond_ex_e & valid_e;
      mem_write_m <= mem_w_e & cond_ex_e & valid_e;
    end
`ifdef COND_IT_BLOCK_EN
  it_state_t  state, state_nx;
  logic [7:0] itstate, itstate_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IT_IDLE;
      itstate <= '0;
    end else begin
      state   <= state_nx;
      itstate <= itstate_nx;
    end
  // The low cond bit shifts in from the mask so each slot picks its then/else sense.
  always_comb begin
    state_nx   = state;
    itstate_nx = itstate;
    if (flush_e) state_nx = IT_IDLE;
    else if (go) begin
      if (state == IT_IDLE) begin
        if (it_start_e && it_mask_e != 4'b0000) begin
          state_nx   = IT_ACTIVE;
          itstate_nx = {it_cond_e, it_mask_e};
        end
      end else if (itstate[3:0] == 4'b1000) state_nx = IT_IDLE;
      else itstate_nx[4:0] = itstate[4:0] << 1;
    end
  end
  assign eff_cond  = state == IT_ACTIVE ? itstate[7:4] : cond_e;
  assign it_active = state == IT_ACTIVE;
`else
  logic unused_it;
  assign unused_it = ^{it_start_e, it_cond_e, it_mask_e};
  assign eff_cond  = cond_e;
  assign it_active = 1'b0;
`endif
endmodule

// File: tb/tb_cond_unit_pipe.sv
// tb_cond_unit_pipe: directed vector table, IT sequence and random stress against a queue-based reference model.
module tb_cond_unit_pipe;
  typedef struct {
    logic       valid, stall, flush;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       pcs, rw, mw, nw, its;
    logic [3:0] itc, itm;
  } in_t;
  typedef struct {
    in_t        i;
    logic       e_pc;
    logic [3:0] e_fl;
    logic       e_rw, e_mw;
  } vec_t;

  logic       clk = 0, reset;
  logic       valid_e, stall_e, flush_e, pcs_e, reg_w_e, mem_w_e, no_write_e, it_start_e;
  logic [3:0] cond_e, alu_flags_e, it_cond_e, it_mask_e;
  logic [1:0] flag_w_e;
  logic       cond_ex_e, pc_src_e, reg_write_m, mem_write_m, it_active;
  logic [3:0] flags;
  int checks = 0, errors = 0;

  logic [3:0] mf;
  logic       mrw, mmw;
  logic [3:0] itq[$];

  always #5 clk = ~clk;

  cond_unit_pipe #(.NGROUPS(2)) dut (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e), .flush_e(flush_e),
    .cond_e(cond_e), .alu_flags_e(alu_flags_e), .flag_w_e(flag_w_e), .pcs_e(pcs_e),
    .reg_w_e(reg_w_e), .mem_w_e(mem_w_e), .no_write_e(no_write_e), .it_start_e(it_start_e),
    .it_cond_e(it_cond_e), .it_mask_e(it_mask_e), .cond_ex_e(cond_ex_e), .pc_src_e(pc_src_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .flags(flags), .it_active(it_active)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Conditions come in true/inverted pairs; cond[0] flips the base test, 14/15 always pass.
  function automatic logic evalc(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v, base;
    {n, z, cc, v} = f;
    base = (c[3:1] == 0) ? z : (c[3:1] == 1) ? cc : (c[3:1] == 2) ? n : (c[3:1] == 3) ? v :
           (c[3:1] == 4) ? (cc && !z) : (c[3:1] == 5) ? (n == v) : (!z && (n == v));
    return (c[3:1] == 7) ? 1'b1 : base ^ c[0];
  endfunction

  function automatic in_t vec(input logic v, s, fl, input logic [3:0] c, a, input logic [1:0] fw,
                              input logic pcs, rw, mw, nw);
    in_t x;
    x = '{valid: v, stall: s, flush: fl, cond: c, alu: a, fw: fw, pcs: pcs, rw: rw, mw: mw, nw: nw,
          its: 1'b0, itc: 4'h0, itm: 4'h0};
    return x;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.valid = $urandom_range(0, 7) != 0;
    x.stall = $urandom_range(0, 7) == 0;
    x.flush = $urandom_range(0, 9) == 0;
    x.cond = 4'($urandom);
    x.alu = 4'($urandom);
    x.fw = 2'($urandom);
    {x.pcs, x.rw, x.mw, x.nw} = 4'($urandom);
    x.its = $urandom_range(0, 3) == 0;
    x.itc = 4'($urandom);
    x.itm = 4'($urandom);
    return x;
  endfunction

  task automatic drive(input in_t x);
    valid_e = x.valid; stall_e = x.stall; flush_e = x.flush; cond_e = x.cond;
    alu_flags_e = x.alu; flag_w_e = x.fw; pcs_e = x.pcs; reg_w_e = x.rw; mem_w_e = x.mw;
    no_write_e = x.nw; it_start_e = x.its; it_cond_e = x.itc; it_mask_e = x.itm;
  endtask

  task automatic model_reset();
    mf = 4'h0; mrw = 1'b0; mmw = 1'b0; itq.delete();
  endtask

  // Called at a negedge: drive, check combinational outputs, clock, check registered outputs.
  task automatic apply(input in_t x, input logic hx, input logic e_pc, input logic [3:0] e_fl,
                       input logic e_rw, input logic e_mw);
    logic go, cx, epc;
    logic [3:0] nf;
    logic nrw, nmw;
    int n;
    drive(x);
    #1;
    go = x.valid && !x.stall && !x.flush;
    cx = evalc(itq.size() != 0 ? itq[0] : x.cond, mf);
    epc = x.pcs && cx && go;
    chk("cond_ex_e", {7'b0, cond_ex_e}, {7'b0, cx});
    chk("pc_src_e", {7'b0, pc_src_e}, {7'b0, epc});
    if (hx) chk("tbl_pc_src_e", {7'b0, pc_src_e}, {7'b0, e_pc});
    nf = mf;
    if (x.fw[0] && cx && go) nf[1:0] = x.alu[1:0];
    if (x.fw[1] && cx && go) nf[3:2] = x.alu[3:2];
    nrw = mrw; nmw = mmw;
    if (x.flush) begin nrw = 0; nmw = 0; end
    else if (!x.stall) begin
      nrw = x.rw && !x.nw && cx && x.valid;
      nmw = x.mw && cx && x.valid;
    end
    @(posedge clk);
    mf = nf; mrw = nrw; mmw = nmw;
    if (x.flush) itq.delete();
    else if (go) begin
      if (itq.size() != 0) void'(itq.pop_front());
`ifdef COND_IT_BLOCK_EN
      else if (x.its && x.itm != 0) begin
        n = x.itm[0] ? 4 : x.itm[1] ? 3 : x.itm[2] ? 2 : 1;
        for (int i = 0; i < n; i++) itq.push_back({x.itc[3:1], i == 0 ? x.itc[0] : x.itm[4-i]});
      end
`endif
    end
    @(negedge clk);
    chk("flags", {4'b0, flags}, {4'b0, mf});
    chk("reg_write_m", {7'b0, reg_write_m}, {7'b0, mrw});
    chk("mem_write_m", {7'b0, mem_write_m}, {7'b0, mmw});
    chk("it_active", {7'b0, it_active}, {7'b0, logic'(itq.size() != 0)});
    if (hx) begin
      chk("tbl_flags", {4'b0, flags}, {4'b0, e_fl});
      chk("tbl_reg_write_m", {7'b0, reg_write_m}, {7'b0, e_rw});
      chk("tbl_mem_write_m", {7'b0, mem_write_m}, {7'b0, e_mw});
    end
  endtask

  vec_t tbl[12];
  in_t  x;

  initial begin
    //          v  s  f  cond   alu    fw    pcs rw mw nw     pc fl     rw mw
    tbl[0]  = '{vec(1, 0, 0, 4'd14, 4'h4, 2'b11, 0, 0, 0, 0), 0, 4'h4, 0, 0};
    tbl[1]  = '{vec(1, 0, 0, 4'd0,  4'h0, 2'b00, 1, 0, 0, 0), 1, 4'h4, 0, 0};
    tbl[2]  = '{vec(1, 0, 0, 4'd1,  4'h0, 2'b00, 1, 0, 0, 0), 0, 4'h4, 0, 0};
    tbl[3]  = '{vec(1, 0, 0, 4'd1,  4'h8, 2'b11, 0, 0, 0, 0), 0, 4'h4, 0, 0};
    tbl[4]  = '{vec(1, 1, 0, 4'd14, 4'h3, 2'b01, 1, 1, 0, 0), 0, 4'h4, 0, 0};
    tbl[5]  = '{vec(1, 1, 0, 4'd14, 4'h3, 2'b01, 1, 1, 0, 0), 0, 4'h4, 0, 0};
    tbl[6]  = '{vec(1, 1, 0, 4'd14, 4'h3, 2'b01, 1, 1, 0, 0), 0, 4'h4, 0, 0};
    tbl[7]  = '{vec(1, 0, 0, 4'd14, 4'h3, 2'b01, 1, 1, 0, 0), 1, 4'h7, 1, 0};
    tbl[8]  = '{vec(1, 0, 0, 4'd14, 4'h0, 2'b00, 0, 1, 1, 0), 0, 4'h7, 1, 1};
    tbl[9]  = '{vec(1, 1, 1, 4'd14, 4'hf, 2'b11, 1, 1, 1, 0), 0, 4'h7, 0, 0};
    tbl[10] = '{vec(1, 0, 0, 4'd14, 4'h0, 2'b00, 0, 1, 1, 1), 0, 4'h7, 0, 1};
    tbl[11] = '{vec(0, 0, 0, 4'd14, 4'h0, 2'b11, 1, 1, 1, 0), 0, 4'h7, 0, 0};

    reset = 1'b0;
    model_reset();
    repeat (4) begin
      drive(rnd());
      @(negedge clk);
      chk("rst_flags", {4'b0, flags}, 8'h00);
      chk("rst_reg_write_m", {7'b0, reg_write_m}, 8'h00);
      chk("rst_mem_write_m", {7'b0, mem_write_m}, 8'h00);
      chk("rst_it_active", {7'b0, it_active}, 8'h00);
    end
    reset = 1'b1;

    foreach (tbl[k]) apply(tbl[k].i, 1, tbl[k].e_pc, tbl[k].e_fl, tbl[k].e_rw, tbl[k].e_mw);

`ifdef COND_IT_BLOCK_EN
    apply(vec(1, 0, 0, 4'd14, 4'h0, 2'b11, 0, 0, 0, 0), 1, 0, 4'h0, 0, 0);
    x = vec(1, 0, 0, 4'd14, 4'h0, 2'b00, 0, 0, 0, 0);
    x.its = 1; x.itc = 4'b0000; x.itm = 4'b0100;
    apply(x, 0, 0, 0, 0, 0);
    chk("it_start_active", {7'b0, it_active}, 8'h01);
    x = vec(1, 0, 0, 4'd14, 4'h0, 2'b00, 0, 1, 0, 0);
    apply(x, 1, 0, 4'h0, 0, 0);
    chk("it_slot1_active", {7'b0, it_active}, 8'h01);
    apply(x, 1, 0, 4'h0, 0, 0);
    chk("it_slot2_active", {7'b0, it_active}, 8'h00);
    apply(x, 1, 0, 4'h0, 1, 0);
`endif

    repeat (400) apply(rnd(), 0, 0, 0, 0, 0);

    drive(rnd());
    #3 reset = 1'b0;
    #1;
    chk("async_rst_flags", {4'b0, flags}, 8'h00);
    chk("async_rst_reg_write_m", {7'b0, reg_write_m}, 8'h00);
    chk("async_rst_mem_write_m", {7'b0, mem_write_m}, 8'h00);
    chk("async_rst_it_active", {7'b0, it_active}, 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (50) apply(rnd(), 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
